// File: rtl/sprite_shatter.sv
// rtl/sprite_shatter.sv - parametrised fragment break-apart sprite; optional colour flicker via SHATTER_FLICKER_EN
module sprite_shatter #(
  parameter int          NUM_PARTS     = 6,
  parameter logic [11:0] COLOR         = 12'hF00,
  parameter int          PART_SIZE     = 8,
  parameter int          SCREEN_W      = 1024,
  parameter int          SCREEN_H      = 768,
  parameter int          KICK_VY       = 4,
  parameter int          GRAVITY       = 1,
  parameter int          GRAV_DIV      = 2,
  parameter int          MAX_VY        = 8,
  parameter logic [11:0] FLICKER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  input  logic        trigger_in,
  input  logic [10:0] x_start_in,
  input  logic [9:0]  y_start_in,
  output logic        in_sprite,
  output logic [11:0] pixel_out,
  output logic        busy_out,
  output logic        done_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic signed [12:0] SW_S    = 13'(SCREEN_W);
  localparam logic signed [12:0] SH_S    = 13'(SCREEN_H);
  localparam logic signed [12:0] PS_S    = 13'(PART_SIZE);
  localparam logic signed [12:0] KICK_S  = 13'(KICK_VY);
  localparam logic signed [12:0] GRAV_S  = 13'(GRAVITY);
  localparam logic signed [12:0] MAXVY_S = 13'(MAX_VY);
  localparam logic [3:0]         GDIV_M1 = 4'(GRAV_DIV - 1);

  state_t                 state_q;
  logic signed [12:0]     x_q [NUM_PARTS];
  logic signed [12:0]     y_q [NUM_PARTS];
  logic signed [12:0]     x_d [NUM_PARTS];
  logic signed [12:0]     y_d [NUM_PARTS];
  logic signed [12:0]     vy_q, vy_d, vy_sum;
  logic [NUM_PARTS-1:0]   alive_q, alive_d, hit;
  logic [3:0]             frame_cnt_q;
  logic                   in_sprite_q, busy_q, done_q;
  logic [11:0]            pixel_q, color_now;
  logic signed [12:0]     h_s, v_s;
  logic                   frame_tick, any_hit;

  assign frame_tick = valid_in && hcount_in == 11'd0 && vcount_in == 10'd0;
  assign h_s = {2'b00, hcount_in};
  assign v_s = {3'b000, vcount_in};

  // Horizontal velocity is a per-slot constant, so it never needs storage.
  function automatic logic signed [12:0] vx_of(input int i);
    return 13'(2 * i - (NUM_PARTS - 1));
  endfunction

  always_comb begin
    vy_sum = vy_q + GRAV_S;
    vy_d   = (vy_sum > MAXVY_S) ? MAXVY_S : vy_sum;
    for (int i = 0; i < NUM_PARTS; i++) begin
      x_d[i]     = x_q[i] + vx_of(i);
      y_d[i]     = y_q[i] + vy_q;
      alive_d[i] = alive_q[i] && !(x_d[i] < 13'sd0 || x_d[i] >= SW_S || y_d[i] >= SH_S);
      hit[i]     = alive_q[i] && (x_q[i] <= h_s) && (h_s < x_q[i] + PS_S)
                              && (y_q[i] <= v_s) && (v_s < y_q[i] + PS_S);
    end
  end

  assign any_hit = valid_in && (|hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alive_q     <= '0;
      vy_q        <= '0;
      frame_cnt_q <= '0;
      in_sprite_q <= 1'b0;
      pixel_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_PARTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      done_q      <= 1'b0;
      in_sprite_q <= any_hit;
      pixel_q     <= any_hit ? color_now : 12'h000;
      case (state_q)
        S_IDLE: if (trigger_in) begin
          for (int i = 0; i < NUM_PARTS; i++) begin
            x_q[i] <= {2'b00, x_start_in};
            y_q[i] <= {3'b000, y_start_in};
          end
          busy_q  <= 1'b1;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          alive_q     <= {NUM_PARTS{1'b1}};
          vy_q        <= -KICK_S;
          frame_cnt_q <= '0;
          state_q     <= S_RUN;
        end
        S_RUN: if (frame_tick) begin
          for (int i = 0; i < NUM_PARTS; i++) begin
            if (alive_q[i]) begin
              x_q[i] <= x_d[i];
              y_q[i] <= y_d[i];
            end
          end
          alive_q <= alive_d;
          if (frame_cnt_q == GDIV_M1) begin
            vy_q        <= vy_d;
            frame_cnt_q <= '0;
          end else begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
          end
          if (alive_d == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SHATTER_FLICKER_EN
  logic [1:0] flick_cnt_q;
  logic       flick_sel_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == S_LOAD) begin
      flick_cnt_q <= '0;
      flick_sel_q <= 1'b0;
    end else if (state_q == S_RUN && frame_tick) begin
      flick_cnt_q <= flick_cnt_q + 2'd1;
      if (flick_cnt_q == 2'd3) flick_sel_q <= ~flick_sel_q;
    end
  end

  assign color_now = flick_sel_q ? FLICKER_COLOR : COLOR;
`else
  assign color_now = COLOR;
`endif

  assign in_sprite = in_sprite_q;
  assign pixel_out = pixel_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_sprite_shatter.sv
// tb/tb_sprite_shatter.sv - self-checking bench for sprite_shatter with a behavioural fragment model
module tb_sprite_shatter;
  localparam int NP = 6, PS = 8, SW = 1024, SH = 768, KICK = 4, GRAV = 1, GDIV = 2, MAXV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        valid_in = 1'b0;
  logic        trigger_in = 1'b0;
  logic [10:0] x_start_in = '0;
  logic [9:0]  y_start_in = '0;
  logic        in_sprite;
  logic [11:0] pixel_out;
  logic        busy_out, done_out;

  int checks = 0;
  int errors = 0;

  sprite_shatter dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .valid_in(valid_in), .trigger_in(trigger_in), .x_start_in(x_start_in),
    .y_start_in(y_start_in), .in_sprite(in_sprite), .pixel_out(pixel_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  int mx[NP], my[NP], mvy, mcnt;
  bit mal[NP];

  function automatic void model_load(input int xs, input int ys);
    for (int i = 0; i < NP; i++) begin mx[i] = xs; my[i] = ys; mal[i] = 1'b1; end
    mvy = -KICK; mcnt = 0;
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < NP; i++) begin
      if (mal[i]) begin
        mx[i] += 2 * i - (NP - 1);
        my[i] += mvy;
        if (mx[i] < 0 || mx[i] >= SW || my[i] >= SH) mal[i] = 1'b0;
      end
    end
    if (mcnt == GDIV - 1) begin
      mvy = (mvy + GRAV > MAXV) ? MAXV : mvy + GRAV;
      mcnt = 0;
    end else mcnt++;
  endfunction

  function automatic bit model_hit(input int h, input int v);
    for (int i = 0; i < NP; i++)
      if (mal[i] && h >= mx[i] && h < mx[i] + PS && v >= my[i] && v < my[i] + PS) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_dead();
    for (int i = 0; i < NP; i++) if (mal[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int h, input int v, input bit val, input bit trg);
    hcount_in = 11'(h); vcount_in = 10'(v); valid_in = val; trigger_in = trg;
    @(posedge clk); #1;
  endtask

  task automatic probe(input string name, input int h, input int v, input bit val);
    bit e;
    e = val && model_hit(h, v);
    cyc(h, v, val, 1'b0);
    chk(name, {in_sprite, pixel_out}, {e, (e ? 12'hF00 : 12'h000)});
  endtask

  task automatic start(input int xs, input int ys);
    x_start_in = 11'(xs); y_start_in = 10'(ys);
    cyc(100, 100, 1'b0, 1'b1);
    model_load(xs, ys);
    chk("busy_after_trigger", busy_out, 1);
    cyc(100, 100, 1'b0, 1'b0);
  endtask

  task automatic run_anim(input int xs, input int ys, input int retrig_at, output int nticks);
    int h, v, j;
    bit fin;
    fin = 1'b0;
    nticks = 0;
    start(xs, ys);
    for (int t = 1; t <= 300 && !fin; t++) begin
      if (t == retrig_at) begin
        x_start_in = 11'd5; y_start_in = 10'd5;
        cyc(200, 200, 1'b0, 1'b1);
      end
      cyc(0, 0, 1'b1, 1'b0);
      model_tick();
      nticks = t;
      chk("done_at_tick", done_out, int'(model_dead()));
      chk("busy_at_tick", busy_out, int'(!model_dead()));
      if (model_dead()) fin = 1'b1;
      else begin
        for (int k = 0; k < 3; k++) begin
          j = $urandom_range(0, NP - 1);
          h = mx[j] + int'($urandom_range(0, PS + 3)) - 2;
          v = my[j] + int'($urandom_range(0, PS + 3)) - 2;
          h = (h < 0) ? 0 : (h > 2047 ? 2047 : h);
          v = (v < 0) ? 0 : (v > 1023 ? 1023 : v);
          if (h == 0 && v == 0) h = 1;
          probe("rand_probe", h, v, $urandom_range(0, 7) != 0);
        end
      end
    end
    if (!fin) chk("anim_timeout", 0, 1);
    cyc(100, 100, 1'b0, 1'b0);
    chk("done_single_pulse", {done_out, busy_out}, 0);
  endtask

  typedef struct {
    int h; int v; bit val; bit exp_in; logic [11:0] exp_pix;
  } vec_t;
  vec_t tbl[7];

  int grav_y[3];
  int bad, n_a, n_b;

  initial begin
    tbl[0] = '{507, 380, 1'b1, 1'b1, 12'hF00};
    tbl[1] = '{506, 380, 1'b1, 1'b0, 12'h000};
    tbl[2] = '{524, 387, 1'b1, 1'b1, 12'hF00};
    tbl[3] = '{525, 387, 1'b1, 1'b0, 12'h000};
    tbl[4] = '{520, 388, 1'b1, 1'b0, 12'h000};
    tbl[5] = '{510, 379, 1'b1, 1'b0, 12'h000};
    tbl[6] = '{510, 383, 1'b0, 1'b0, 12'h000};
    grav_y[0] = 376; grav_y[1] = 373; grav_y[2] = 370;

    cyc(100, 100, 1'b0, 1'b0);
    cyc(100, 100, 1'b0, 1'b0);
    rst = 1'b0;
    chk("reset_outputs", {in_sprite, pixel_out, busy_out, done_out}, 0);
    probe("idle_no_sprite", 512, 384, 1'b1);

    start(512, 384);
    cyc(0, 0, 1'b1, 1'b0);
    model_tick();
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].h, tbl[i].v, tbl[i].val, 1'b0);
      chk($sformatf("table_%0d", i), {in_sprite, pixel_out}, {tbl[i].exp_in, tbl[i].exp_pix});
    end

    for (int t = 0; t < 3; t++) begin
      cyc(0, 0, 1'b1, 1'b0);
      model_tick();
      cyc(511, grav_y[t], 1'b1, 1'b0);
      chk($sformatf("grav_top_tick%0d", t + 2), in_sprite, 1);
      cyc(511, grav_y[t] - 1, 1'b1, 1'b0);
      chk($sformatf("grav_above_tick%0d", t + 2), in_sprite, 0);
    end

    rst = 1'b1;
    cyc(511, 370, 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrun_reset", {in_sprite, busy_out, done_out}, 0);
    bad = 0;
    cyc(0, 0, 1'b1, 1'b0);
    for (int v = 360; v < 396; v++)
      for (int h = 496; h < 536; h += 3) begin
        cyc(h, v, 1'b1, 1'b0);
        if (in_sprite || done_out || busy_out || pixel_out != 12'h000) bad++;
      end
    chk("post_reset_scan", bad, 0);

    run_anim(1020, 700, 0, n_a);
    run_anim(512, 384, 0, n_a);
    run_anim(512, 384, 5, n_b);
    chk("retrigger_done_timing", n_b, n_a);
    for (int r = 0; r < 6; r++)
      run_anim($urandom_range(0, SW - 1), $urandom_range(0, SH - 1), 0, n_a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
